// File: rtl/axi4_memory_bank.sv
// Dual-port word memory with byte strobes, optional post-reset zero-fill sweep, write-first collisions.
// Latency: READ_LATENCY cycles from accepted rd_en to rd_valid; writes land on the accepting edge.
// Backpressure: none; one write and one read per cycle, both ignored while init_busy is high.
module axi4_memory_bank #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   sweep_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_ok, rd_ok, wr_go, rd_go;
    logic [IW-1:0]         wr_idx, rd_idx, sweep_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [READ_LATENCY-1:0] pv;
    logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];
    logic [READ_LATENCY-1:0] pe;

    // Range checks use the full address width so out-of-range never aliases.
    assign wr_ok     = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok     = ({1'b0, rd_addr} < DEPTH_W);
    assign wr_go     = wr_en && wr_ok && (state_q == READY);
    assign rd_go     = rd_en && (state_q == READY);
    assign wr_idx    = wr_addr[IW-1:0];
    assign rd_idx    = rd_addr[IW-1:0];
    assign sweep_idx = sweep_cnt[IW-1:0];
    assign init_busy = (state_q == INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (INIT_ZERO != 0) ? INIT : READY;
            sweep_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && sweep_cnt == LAST_W) state_d = READY;
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[sweep_idx] <= '0;
        end else if (wr_go) begin
            for (int b = 0; b < NB; b++)
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Write-first: a same-edge write to the read address is merged into the read word.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[rd_idx];
            if (wr_go && wr_addr == rd_addr)
                for (int b = 0; b < NB; b++)
                    if (wr_strb[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
        end else begin
            pv[0] <= rd_go;
            if (rd_go) begin
                pd[0] <= rd_word;
                pe[0] <= !rd_ok;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                    pe[i] <= pe[i-1];
                end
            end
        end
    end

    assign rd_valid = pv[READ_LATENCY-1];
    assign rd_data  = pd[READ_LATENCY-1];
    assign rd_err   = pe[READ_LATENCY-1];
endmodule
